// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and default sizing for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;
  localparam int DATA_W_DEF      = 8;
  localparam int ACK_TIMEOUT_DEF = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among masked requests, searching upward from ptr_i+1
//   req_i  : raw request vector
//   mask_i : requests allowed to compete (all ones when unlocked)
//   ptr_i  : last winner; the search starts just above it and wraps
//   gnt_o  : one-hot winner, idx_o : winner index, any_o : some request eligible
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] elig;
  assign elig = req_i & mask_i;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_o && elig[(int'(ptr_i) + k) % N]) begin
        any_o = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter between N_REQ byte sources with packet lock
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester byte stream (valid/ready, one-hot ready)
//   tx_data/tx_start/tx_busy : transmitter interface (tx_start is a one-cycle pulse)
//   grant_id     : current/last granted requester
//   lock_active  : a multi-byte packet owns the transmitter
//   err_timeout  : one-cycle pulse when tx_busy never rose after tx_start
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         grant_id,
  output logic                    lock_active,
  output logic                    err_timeout
);
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]   grant_q, grant_d, ptr_q, ptr_d;
  logic              lock_q, lock_d, err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  mask, gnt;
  logic [ID_W-1:0]   win;
  logic              any, accept;

  // While locked only the packet owner may compete; others stall even if the owner goes quiet.
  assign mask = lock_q ? N_REQ'(1) << grant_q : '1;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i (req_valid),
    .mask_i(mask),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  assign accept      = (state_q == IDLE) && any && !tx_busy;
  assign req_ready   = accept ? gnt : '0;
  assign tx_start    = state_q == START;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign lock_active = lock_q;
  assign err_timeout = err_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        tx_data_d = req_data[int'(win)*DATA_W +: DATA_W];
        grant_d   = win;
        ptr_d     = win;
        lock_d    = ~req_last[win];
        state_d   = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      else begin
        cnt_d = cnt_q + 1'b1;
        // Counter is about to reach ACK_TIMEOUT-1: drop the byte and release any lock.
        if (cnt_q == CW'(ACK_TIMEOUT - 2)) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      grant_q   <= '0;
      ptr_q     <= ID_W'(N_REQ - 1);
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the round-robin UART transmit arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   tx_data;
  logic           tx_start, tx_busy, lock_active, err_timeout;
  logic [1:0]     grant_id;

  int checks = 0, failures = 0;
  logic [8:0] src_mem [N][16];
  int src_wr [N] = '{default: 0};
  int src_rd [N] = '{default: 0};
  logic [9:0] sb [$];
  logic [9:0] exp_w;
  int bcnt = 0;
  logic model_en = 1'b1, force_busy = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .ACK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .lock_active(lock_active),
    .err_timeout(err_timeout)
  );

  // Byte sources: each requester presents the head of its own FIFO of {last, byte}.
  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = src_rd[i] != src_wr[i];
      req_last[i]        = src_mem[i][src_rd[i] % 16][8];
      req_data[i*W +: W] = src_mem[i][src_rd[i] % 16][7:0];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) src_rd[i] <= src_rd[i] + 1;

  // Transmitter model: busy rises 2 cycles after tx_start and stays high for 10 cycles.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (tx_start && model_en) bcnt <= 1;
    else if (bcnt == 11) bcnt <= 0;
    else if (bcnt > 0) bcnt <= bcnt + 1;
  assign tx_busy = force_busy || bcnt >= 2;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(int id, logic [7:0] b, logic last);
    src_mem[id][src_wr[id] % 16] = {last, b};
    src_wr[id] = src_wr[id] + 1;
  endtask

  task automatic expect_tx(int id, logic [7:0] b);
    sb.push_back({2'(id), b});
  endtask

  task automatic wait_start(string name, int max);
    int k;
    for (k = 0; k < max; k++) begin
      @(negedge clk);
      if (tx_start) break;
    end
    chk(name, k < max, 1);
  endtask

  task automatic drain(string name, int max);
    int k;
    for (k = 0; k < max; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && bcnt == 0 && !tx_busy && !tx_start) break;
    end
    chk(name, k < max, 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every tx_start must match the oldest expected {grant_id, byte}.
  always @(negedge clk)
    if (rst_n) begin
      if (tx_start) begin
        chk("start_while_busy", tx_busy, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got id=%0d data=%0h expected none", grant_id, tx_data);
        end else begin
          exp_w = sb.pop_front();
          chk("start_id_data", {grant_id, tx_data}, exp_w);
        end
      end
      if (req_ready != '0)
        chk("ready_onehot_valid", $onehot(req_ready) && ((req_ready & ~req_valid) == '0), 1);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, bad;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_lock", lock_active, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", req_ready, 0);
    // single byte
    load(0, 8'hCF, 1'b1);
    expect_tx(0, 8'hCF);
    #1 chk("t1_ready", req_ready, 4'b0001);
    @(negedge clk);
    chk("t1_start_next", tx_start, 1);
    chk("t1_data", tx_data, 8'hCF);
    @(negedge clk);
    chk("t1_start_pulse", tx_start, 0);
    drain("t1_drain", 40);
    chk("t1_lock", lock_active, 0);
    // contention after fresh reset: order 0,1,2,3,0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load(0, 8'hA0, 1'b1); load(0, 8'hA4, 1'b1);
    load(1, 8'hA1, 1'b1); load(2, 8'hA2, 1'b1); load(3, 8'hA3, 1'b1);
    expect_tx(0, 8'hA0); expect_tx(1, 8'hA1); expect_tx(2, 8'hA2);
    expect_tx(3, 8'hA3); expect_tx(0, 8'hA4);
    #1 chk("t2_first_ready", req_ready, 4'b0001);
    drain("t2_drain", 200);
    // packet lock
    load(0, 8'hB0, 1'b0); load(0, 8'hB1, 1'b0); load(0, 8'hB2, 1'b1);
    expect_tx(0, 8'hB0); expect_tx(0, 8'hB1); expect_tx(0, 8'hB2); expect_tx(1, 8'hC0);
    wait_start("t3_s1", 5);
    chk("t3_lock1", lock_active, 1);
    load(1, 8'hC0, 1'b1);
    wait_start("t3_s2", 40);
    chk("t3_lock2", lock_active, 1);
    wait_start("t3_s3", 40);
    chk("t3_lock3", lock_active, 0);
    drain("t3_drain", 100);
    // timeout: transmitter never answers
    model_en = 1'b0;
    load(2, 8'h5A, 1'b0);
    expect_tx(2, 8'h5A);
    wait_start("t4_start", 5);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (err_timeout) break;
    end
    chk("t4_err_delay", n, TO);
    chk("t4_lock_cleared", lock_active, 0);
    model_en = 1'b1;
    load(3, 8'h3C, 1'b1);
    expect_tx(3, 8'h3C);
    #1 chk("t4_next_ready", req_ready, 4'b1000);
    @(negedge clk);
    chk("t4_err_pulse", err_timeout, 0);
    drain("t4_drain", 60);
    // reset during WAIT_LO with busy held high
    load(1, 8'h77, 1'b1);
    expect_tx(1, 8'h77);
    wait_start("t5_start", 5);
    repeat (4) @(negedge clk);
    chk("t5_in_frame", tx_busy, 1);
    force_busy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_start", tx_start, 0);
    chk("t5_rst_data", tx_data, 0);
    chk("t5_rst_grant", grant_id, 0);
    chk("t5_rst_lock", lock_active, 0);
    chk("t5_rst_err", err_timeout, 0);
    chk("t5_rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(2, 8'h99, 1'b1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (req_ready != '0) bad++;
    end
    chk("t5_no_ready_busy", bad, 0);
    expect_tx(2, 8'h99);
    force_busy = 1'b0;
    #1 chk("t5_ready_req2", req_ready, 4'b0100);
    drain("t5_drain", 60);
    // lock held by a stalled owner
    load(0, 8'h10, 1'b0);
    expect_tx(0, 8'h10);
    wait_start("t6_s1", 5);
    chk("t6_lock", lock_active, 1);
    load(3, 8'h33, 1'b1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (req_ready[3]) bad++;
    end
    chk("t6_req3_stalled", bad, 0);
    chk("t6_lock_held", lock_active, 1);
    load(0, 8'h11, 1'b1);
    expect_tx(0, 8'h11);
    expect_tx(3, 8'h33);
    drain("t6_drain", 100);
    chk("t6_lock_end", lock_active, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
